debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel, parametrised button/encoder-pin debouncer: it filters CHANNELS asynchronous mechanical inputs into clean levels and emits one-cycle press/release strobes. It has a programmable sample prescaler and counter-based stability filtering, so long bounce windows need no wide shift registers. It sits between the top-level input pins and the encoder/control logic. It supersedes per-pin single-channel debouncers.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- STABLE_COUNT, 8: consecutive disagreeing samples required to flip a channel's output (≥1).
- PRESCALE, 1: clocks per sample strobe (≥1; 1 = sample every clock).
- INIT_LEVEL, 0: reset value of every debounced output (0 or 1).
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- buttons  input  CHANNELS  raw inputs, bit i = channel i.
- debounced  output  CHANNELS  filtered level per channel, registered.
- rise  output  CHANNELS  one-clock pulse when debounced[i] goes 0→1.
- fall  output  CHANNELS  one-clock pulse when debounced[i] goes 1→0.

## Operation
- Prescaler: counter 0..PRESCALE-1, wraps to 0. The strobe is high in the cycle the counter equals PRESCALE-1. With PRESCALE=1 the strobe is constantly high. One prescaler is shared by all channels.
- Per channel, each strobe cycle:
  - sample == debounced[i]: the stability counter clears to 0.
  - sample != debounced[i] and counter == STABLE_COUNT-1: debounced[i] toggles, the counter clears, and rise[i] or fall[i] asserts.
  - Otherwise the counter increments.
- A single agreeing sample restarts the count, so a bounce of any length resets the filter.
- Non-strobe cycles: counters and levels hold, rise and fall are 0.
- The counter is $clog2(STABLE_COUNT) bits wide, minimum 1. It never exceeds STABLE_COUNT-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous flips on several channels each produce their own pulses in the same cycle.
- rise and fall are never both high on one channel. A channel flips at most once per strobe.
- Reset (any time, including mid-count):
  - prescaler = 0, all counters = 0, debounced = {CHANNELS{INIT_LEVEL}}, rise = fall = 0.
  - No pulse is generated on reset release, even if the inputs differ from INIT_LEVEL. Normal filtering then applies.

## Timing
- The input is sampled at strobe edges only.
- Without a synchroniser, an input held stably at the new level from strobe k flips debounced at the clock edge of strobe k+STABLE_COUNT-1. That is STABLE_COUNT strobes including k, i.e. (STABLE_COUNT-1)*PRESCALE clocks after the first qualifying strobe.
- rise/fall are registered, high for exactly the one clock in which debounced has just changed (aligned with the new level).
- The first strobe after reset release occurs PRESCALE-1 clocks after the first active edge.

## Configuration
- DEBOUNCE_SYNC_EN defined: each buttons bit passes through a 2-flop synchroniser, reset to INIT_LEVEL, before sampling. This adds exactly 2 clocks of latency to every response.
- DEBOUNCE_SYNC_EN undefined: buttons feeds the sample logic directly. In that case the inputs must already be synchronous to clk.

## Structure
- Shared package debounce_pkg:
  - the counter-width function (clog2 with minimum 1);
  - default constants for STABLE_COUNT and PRESCALE used across the design.
- Sub-module debounce_channel holds one channel's counter, level register and edge pulses. The top generates CHANNELS instances.
- The prescaler and the optional synchronisers live in debounce_bank.

## Test plan
- Defaults, no sync. Reset, then hold buttons=4'b0001. debounced[0] rises at the 8th sampling edge (7 clocks after the first). rise[0] is high for 1 clock. Other channels stay 0 with no pulses.
- Bounce: on ch1, drive 1 for 5 clocks, 0 for 1 clock, then 1. debounced[1] rises exactly 8 clocks after the final 0→1, not earlier.
- PRESCALE=4, STABLE_COUNT=3: a step on ch2 aligned to a strobe flips debounced[2] 8 clocks later. A 0-glitch on a non-strobe clock is ignored.
- Simultaneous events: from debounced=4'b0011, step buttons to 4'b1100. After 8 strobes, fall=4'b0011 and rise=4'b1100 in the same cycle, debounced=4'b1100.
- Reset mid-count: pull reset_n low at count 5 on ch0. Outputs go to INIT_LEVEL immediately (asynchronously). After release, 8 full samples are required again. There is no pulse at release. With INIT_LEVEL=1 and buttons held at 1, nothing ever pulses.
- DEBOUNCE_SYNC_EN defined: repeat the first scenario. The flip occurs exactly 2 clocks later than in the no-sync run.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and counter-width helper for the debounce bank
package debounce_pkg;

  localparam int DEFAULT_STABLE_COUNT = 8;
  localparam int DEFAULT_PRESCALE     = 1;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_if.sv
// rtl/debounce_if.sv - raw button inputs and filtered level/edge outputs of the debounce bank
interface debounce_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] buttons;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (output buttons, input debounced, input rise, input fall);
  modport slave  (input buttons, output debounced, output rise, output fall);

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: stability counter, level register and edge pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  input  logic sample,
  output logic debounced,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [CW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (strobe) begin
        // Any agreeing sample restarts the filter, so bounces never accumulate.
        if (sample == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= ~level;
          rise  <= ~level;
          fall  <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign debounced = level;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with shared prescaler; DEBOUNCE_SYNC_EN adds 2-flop input synchronisers
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int   PRESCALE     = DEFAULT_PRESCALE,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic     clk,
  input  logic     reset_n,
  debounce_if.slave bus
);

  logic                strobe;
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] deb_w;
  logic [CHANNELS-1:0] rise_w;
  logic [CHANNELS-1:0] fall_w;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= {CHANNELS{INIT_LEVEL}};
      sync_q2 <= {CHANNELS{INIT_LEVEL}};
    end else begin
      sync_q1 <= bus.buttons;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = bus.buttons;
`endif

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int            PW       = cnt_width(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      assign strobe = (pre_cnt == PRE_LAST);
    end else begin : g_nopre
      assign strobe = 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
        .STABLE_COUNT (STABLE_COUNT),
        .INIT_LEVEL   (INIT_LEVEL)
      ) u_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe    (strobe),
        .sample    (sample[i]),
        .debounced (deb_w[i]),
        .rise      (rise_w[i]),
        .fall      (fall_w[i])
      );
    end
  endgenerate

  assign bus.debounced = deb_w;
  assign bus.rise      = rise_w;
  assign bus.fall      = fall_w;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank; timing expectations follow DEBOUNCE_SYNC_EN
module tb_debounce_bank;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   i_pulses = 0;

  always #5 clk = ~clk;

  debounce_if #(.CHANNELS(4)) bus_d ();
  debounce_if #(.CHANNELS(4)) bus_p ();
  debounce_if #(.CHANNELS(4)) bus_i ();

  debounce_bank #(.CHANNELS(4), .STABLE_COUNT(8), .PRESCALE(1), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_d));
  debounce_bank #(.CHANNELS(4), .STABLE_COUNT(3), .PRESCALE(4), .INIT_LEVEL(1'b0)) dut_p (
    .clk(clk), .reset_n(reset_n), .bus(bus_p));
  debounce_bank #(.CHANNELS(4), .STABLE_COUNT(8), .PRESCALE(1), .INIT_LEVEL(1'b1)) dut_i (
    .clk(clk), .reset_n(reset_n), .bus(bus_i));

  typedef struct {
    logic [3:0] buttons;
    int         cycles;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t       tbl[11];
  logic [3:0] seq_btn[$];
  int         seq_chk[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus_i.rise | bus_i.fall) != 4'b0000) i_pulses++;
  end

  initial begin
    int flip_edge;
    int early;
    logic [3:0] flip_rise;
    logic [3:0] next_rise;
    logic [3:0] prev_deb;

    tbl[0]  = '{4'b0001, 7, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0011, 5, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0011, 7, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0011, 1, 4'b0011, 4'b0010, 4'b0000};
    tbl[7]  = '{4'b1100, 7, 4'b0011, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1100, 1, 4'b1100, 4'b1100, 4'b0011};
    tbl[9]  = '{4'b1100, 1, 4'b1100, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0100, 8, 4'b0100, 4'b0000, 4'b1000};

    bus_d.buttons = 4'b0000;
    bus_p.buttons = 4'b0000;
    bus_i.buttons = 4'b1111;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_deb", bus_d.debounced, 4'b0000);
    check("reset_rise", bus_d.rise, 4'b0000);
    check("reset_fall", bus_d.fall, 4'b0000);
    check("reset_deb_p", bus_p.debounced, 4'b0000);
    check("reset_deb_init1", bus_i.debounced, 4'b1111);
    reset_n = 1'b1;

    // Table: level flip, bounce restart, simultaneous rise/fall, fall
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        seq_btn.push_back(tbl[i].buttons);
        seq_chk.push_back((c == tbl[i].cycles - 1) ? i : -1);
      end
    end
    for (int k = 0; k < seq_btn.size() + SYNC_LAT; k++) begin
      int j;
      bus_d.buttons = (k < seq_btn.size()) ? seq_btn[k] : seq_btn[seq_btn.size() - 1];
      @(posedge clk);
      @(negedge clk);
      j = k - SYNC_LAT;
      if (j >= 0 && seq_chk[j] >= 0) begin
        check($sformatf("tbl%0d_deb", seq_chk[j]), bus_d.debounced, tbl[seq_chk[j]].deb);
        check($sformatf("tbl%0d_rise", seq_chk[j]), bus_d.rise, tbl[seq_chk[j]].rise);
        check($sformatf("tbl%0d_fall", seq_chk[j]), bus_d.fall, tbl[seq_chk[j]].fall);
      end
    end

    // Reset in the middle of a count on ch0, with ch2 already high
    bus_d.buttons = 4'b0101;
    repeat (5 + SYNC_LAT) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_deb", bus_d.debounced, 4'b0000);
    check("async_reset_pulse", bus_d.rise | bus_d.fall, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    flip_edge = -1;
    early = 0;
    flip_rise = 4'b0000;
    for (int e = 1; e <= 40 && flip_edge < 0; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_d.debounced != 4'b0000) begin
        flip_edge = e;
        flip_rise = bus_d.rise;
      end else if ((bus_d.rise | bus_d.fall) != 4'b0000) begin
        early = 1;
      end
    end
    check_int("restart_flip_edge", flip_edge, 8 + SYNC_LAT);
    check("restart_flip_rise", flip_rise, 4'b0101);
    check_int("release_no_pulse", early, 0);

    // PRESCALE=4, STABLE_COUNT=3: strobe-aligned step on ch2 plus a non-strobe glitch
    bus_p.buttons = 4'b0000;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    flip_edge = -1;
    flip_rise = 4'b0000;
    next_rise = 4'b1111;
    prev_deb = 4'b0000;
    for (int e = 1; e <= 30; e++) begin
      if (e == 6 - SYNC_LAT) bus_p.buttons = 4'b0000;
      else if (e >= 4 - SYNC_LAT) bus_p.buttons = 4'b0100;
      @(posedge clk);
      @(negedge clk);
      if (flip_edge > 0 && e == flip_edge + 1) next_rise = bus_p.rise;
      if (flip_edge < 0 && bus_p.debounced != prev_deb) begin
        flip_edge = e;
        flip_rise = bus_p.rise;
        check("pre_flip_level", bus_p.debounced, 4'b0100);
      end
    end
    check_int("pre_flip_edge", flip_edge, 12);
    check("pre_flip_rise", flip_rise, 4'b0100);
    check("pre_rise_width", next_rise, 4'b0000);

    // INIT_LEVEL=1 with buttons held high never pulses
    check_int("init1_pulses", i_pulses, 0);
    check("init1_deb", bus_i.debounced, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
